// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and the step-counter width helper.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 2) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         busy;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout, busy
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout, busy
    );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder built from explicit full-adder equations; the only
// datapath adder in the nibble-serial adder.
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit ripple adder over NIBBLES cycles, LSB nibble
// first, with valid/ready handshakes on both operand and result sides.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_IDLE | waiting for operands, in_ready high
//  ST_RUN  | one nibble added per cycle, carry registered between nibbles
//  ST_DONE | Sum/Cout/out_valid held until out_ready
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    nibble_serial_adder_if.slave  bus
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic [W-1:0]  sum_next;
    logic          carry_q;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          out_valid_q;

    logic [3:0]    rca_sum;
    logic          rca_cout;
    logic          accept;
    logic          last;
    logic          release_out;

    ripple_carry_adder_4bit U_RCA (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // New nibble enters at the top so the LSB nibble ends up at the bottom.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_next = rca_sum;
        end else begin : g_multi
            assign sum_next = {rca_sum, sum_sh[W-1:NIBBLE_W]};
        end
    endgenerate

    assign accept      = (state_q == ST_IDLE) && bus.in_valid;
    assign last        = (cnt == CNT_LAST);
    assign release_out = (state_q == ST_DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last)          state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_sh    <= bus.A;
                b_sh    <= bus.B;
                carry_q <= bus.Cin;
                cnt     <= '0;
            end
            if (state_q == ST_RUN) begin
                a_sh    <= a_sh >> NIBBLE_W;
                b_sh    <= b_sh >> NIBBLE_W;
                sum_sh  <= sum_next;
                carry_q <= rca_cout;
                cnt     <= cnt + CW'(1);
                if (last) begin
                    sum_q       <= sum_next;
                    cout_q      <= rca_cout;
                    out_valid_q <= 1'b1;
                end
            end
            if (release_out) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;

endmodule
